// File: rtl/data_buffer.sv
// data_buffer -- shared byte FIFO between the AHB-lite register block and the
// USB RX/TX packet engines.
//
// Two producers share one write port (the USB RX engine wins over the host),
// and two consumers share one first-word-fall-through read port (a request
// from either consumer, or both together, pops exactly one entry). Occupancy
// is the difference of two pointers that are one bit wider than the entry
// address, so full and empty can be told apart without a separate flag.
//
// Ports
//   clk                   system clock, rising edge
//   n_rst                 asynchronous active-low reset
//   store_tx_data/tx_data host push request and byte
//   get_rx_data           host pop request
//   rx_data               head byte for the host (0 when empty)
//   store_rx_packet_data/rx_packet_data  USB RX engine push request and byte
//   get_tx_packet_data    USB TX engine pop request
//   tx_packet_data        head byte for the TX engine (0 when empty)
//   clear                 synchronous flush, overrides all pushes and pops
//   buffer_occupancy      number of bytes held, 0..DEPTH
module data_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              store_tx_data,
  input  logic [7:0]        tx_data,
  input  logic              get_rx_data,
  output logic [7:0]        rx_data,
  input  logic              store_rx_packet_data,
  input  logic [7:0]        rx_packet_data,
  input  logic              get_tx_packet_data,
  output logic [7:0]        tx_packet_data,
  input  logic              clear,
  output logic [ADDR_W:0]   buffer_occupancy
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;

  logic [ADDR_W:0] occ;
  logic            empty;
  logic            full;
  logic            push_ok;
  logic            pop_ok;
  logic [7:0]      push_byte;
  logic [7:0]      head;

  // Modulo-2^(ADDR_W+1) subtraction handles pointer wrap with no special case.
  assign occ   = wptr_q - rptr_q;
  assign empty = (occ == '0);
  assign full  = (occ == FULL_CNT);

  // Full/empty are judged on the pre-edge occupancy, so a push and a pop in
  // the same cycle are accepted independently against the current state.
  assign push_ok   = (store_rx_packet_data | store_tx_data) & ~full  & ~clear;
  assign pop_ok    = (get_rx_data | get_tx_packet_data)     & ~empty & ~clear;
  assign push_byte = store_rx_packet_data ? rx_packet_data : tx_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array is reset to zero because reset must discard all
  // contents immediately; this forces flops rather than a RAM macro, which is
  // acceptable at this depth. clear, by contrast, only moves the pointers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= push_byte;
    end
  end

  // First-word fall-through: the head is visible before the pop strobe, and
  // forced to zero when empty so stale bytes never leak out.
  assign head             = empty ? 8'h00 : mem_q[rptr_q[ADDR_W-1:0]];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = occ;

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer. A byte queue models the FIFO: pushes
// append, pops remove the front, clear/reset empty it. Before each clock edge
// the DUT's head bytes and occupancy are compared with the queue.
module tb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic       clear;
  logic [6:0] buffer_occupancy;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .clear                (clear),
    .buffer_occupancy     (buffer_occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_head;
    exp_head = (q.size() == 0) ? 8'h00 : q[0];
    check({tag, "_occ"},     32'(buffer_occupancy), 32'(q.size()));
    check({tag, "_rx_data"}, 32'(rx_data),          32'(exp_head));
    check({tag, "_tx_data"}, 32'(tx_packet_data),   32'(exp_head));
  endtask

  // One clock cycle: drive inputs after the falling edge, compare the current
  // state, then advance the model by the FIFO rules for this cycle's requests.
  task automatic step(input string tag,
                      input logic srx, input logic [7:0] drx,
                      input logic stx, input logic [7:0] dtx,
                      input logic grx, input logic gtx, input logic clr);
    int  sz;
    bit  do_pop, do_push;
    @(negedge clk);
    store_rx_packet_data = srx;
    rx_packet_data       = drx;
    store_tx_data        = stx;
    tx_data              = dtx;
    get_rx_data          = grx;
    get_tx_packet_data   = gtx;
    clear                = clr;
    #1;
    check_outputs(tag);
    sz = q.size();
    if (clr) begin
      q.delete();
    end else begin
      do_pop  = (grx || gtx) && (sz != 0);
      do_push = (srx || stx) && (sz != 64);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(srx ? drx : dtx);
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic reset_mid_cycle(input string tag);
    @(negedge clk);
    store_rx_packet_data = 1'b0;
    store_tx_data        = 1'b0;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    clear                = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    q.delete();
    check_outputs(tag);
    @(negedge clk);
    check_outputs({tag, "_held"});
    n_rst = 1'b1;
  endtask

  initial begin
    int sz;
    bit pu, po;
    int sel;

    n_rst                = 1'b0;
    store_tx_data        = 1'b0;
    tx_data              = 8'h00;
    get_rx_data          = 1'b0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    get_tx_packet_data   = 1'b0;
    clear                = 1'b0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Host fill, TX drain.
    step("host_push", 0, 8'h00, 1, 8'h11, 0, 0, 0);
    step("host_push", 0, 8'h00, 1, 8'h22, 0, 0, 0);
    step("host_push", 0, 8'h00, 1, 8'h33, 0, 0, 0);
    step("host_push", 0, 8'h00, 1, 8'h44, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("tx_pop", 0, 8'h00, 0, 8'h00, 0, 1, 0);
    idle("drained");
    check("drained_occ_zero", 32'(buffer_occupancy), 32'd0);

    // Fill to full from the RX engine, overflow, then simultaneous push/pop.
    for (int i = 0; i < 64; i++) step("fill", 1, 8'(i), 0, 8'h00, 0, 0, 0);
    step("overflow", 1, 8'hAA, 0, 8'h00, 0, 0, 0);
    check("full_occ", 32'(buffer_occupancy), 32'd64);
    step("full_push_pop", 1, 8'hBB, 0, 8'h00, 1, 0, 0);
    idle("after_full_push_pop");
    check("after_full_rx", 32'(rx_data), 32'h01);

    // Drain with mixed strobes; pointers are left mid-range so the next
    // phase crosses both the address wrap and the pointer wrap.
    for (int i = 0; q.size() != 0 && i < 100; i++)
      step("drain", 0, 8'h00, 0, 8'h00, (i % 3) != 1, (i % 3) != 0, 0);
    idle("drain_done");

    // Interleaved traffic holding occupancy within 1..3.
    step("wrap_prime", 0, 8'h00, 1, 8'h5A, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      sz = q.size();
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if (sz >= 3 && pu && !po) po = 1'b1;
      if (sz <= 1 && po && !pu) pu = 1'b1;
      sel = $urandom_range(0, 2);
      step("wrap", pu && sel[0], 8'($urandom), pu && !sel[0], 8'($urandom),
           po && sel != 1, po && sel != 0, 0);
      check("wrap_bound", 32'(buffer_occupancy <= 7'd3), 32'd1);
    end

    // Conflicting pushes and conflicting pops.
    step("clear_pre_conflict", 0, 8'h00, 0, 8'h00, 0, 0, 1);
    step("dual_push", 1, 8'h66, 1, 8'h55, 0, 0, 0);
    idle("dual_push_result");
    check("dual_push_value", 32'(rx_data), 32'h66);
    step("push", 0, 8'h00, 1, 8'h12, 0, 0, 0);
    step("push", 1, 8'h34, 0, 8'h00, 0, 0, 0);
    step("dual_pop", 0, 8'h00, 0, 8'h00, 1, 1, 0);
    idle("dual_pop_result");
    check("dual_pop_occ", 32'(buffer_occupancy), 32'd2);

    // Flush with a concurrent push.
    for (int i = 0; i < 8; i++) step("flush_fill", 0, 8'h00, 1, 8'(8'hC0 + i), 0, 0, 0);
    step("flush", 0, 8'h00, 1, 8'h77, 0, 0, 1);
    idle("after_flush");
    check("after_flush_rx", 32'(rx_data), 32'h00);
    step("post_flush_push", 1, 8'h99, 0, 8'h00, 0, 0, 0);
    idle("post_flush_head");

    // Random traffic in biased phases so full, empty and clear all occur.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        pu = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 25));
        po = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 80));
        step("random", pu && $urandom_range(0, 1) == 1, 8'($urandom),
             pu && $urandom_range(0, 1) == 1, 8'($urandom),
             po && $urandom_range(0, 1) == 1, po && $urandom_range(0, 1) == 1,
             $urandom_range(0, 199) == 0);
      end
    end

    // Mid-transfer reset with data present.
    for (int i = 0; i < 5; i++) step("pre_reset", 0, 8'h00, 1, 8'(8'hE0 + i), 0, 0, 0);
    reset_mid_cycle("mid_reset");
    idle("post_reset");
    step("post_reset_push", 0, 8'h00, 1, 8'h3C, 0, 0, 0);
    idle("post_reset_head");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
